// File: rtl/alu_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_req_arbiter_pkg
//  Brief    : Opcode and FSM state encodings shared by the ALU arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package alu_req_arbiter_pkg;

  // ALU operation encodings (2-bit op field on each request port)
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  // Arbiter FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage : alu_req_arbiter_pkg
`default_nettype wire

// File: rtl/alu_req_arbiter_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Brief    : Combinational AND / ADD / SUB / CMP datapath with a per-op
//             status flag. Unsigned operands, result truncated to WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_req_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             flag
);

  // One extra bit holds the carry (ADD) or borrow (SUB) out of the MSB.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Select result and flag for the requested operation.
  always_comb begin
    y    = '0;
    flag = 1'b0;
    case (op)
      OP_AND: begin
        y    = a & b;
        flag = ((a & b) == '0);
      end
      OP_ADD: begin
        y    = w_sum[WIDTH-1:0];
        flag = w_sum[WIDTH];
      end
      OP_SUB: begin
        y    = w_diff[WIDTH-1:0];
        flag = w_diff[WIDTH];
      end
      default: begin
        // CMP: one-hot {lt, gt, eq} in the low three bits.
        y[2] = (a < b);
        y[1] = (a > b);
        y[0] = (a == b);
        flag = (a == b);
      end
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_req_arbiter
//  Brief    : Shares one ALU datapath between two valid/ready requesters with
//             round-robin arbitration and a registered valid/ready response.
//             One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_flag,
  output logic             busy
);

  logic [1:0]       r_state;
  logic             r_rr_ptr;   // 0: req0 wins a tie, 1: req1 wins a tie
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_flag;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_idle;
  logic [WIDTH-1:0] w_y;
  logic             w_flag;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  assign w_grant0 = req0_valid & (~req1_valid | ~r_rr_ptr);
  assign w_grant1 = req1_valid & (~req0_valid |  r_rr_ptr);
  assign w_idle   = (r_state == S_IDLE);

  // Ready is held low while reset is asserted so nothing handshakes into reset.
  assign req0_ready = ~rst & w_idle & w_grant0;
  assign req1_ready = ~rst & w_idle & w_grant1;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_flag  = r_rsp_flag;
  assign busy      = ~w_idle;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .op   (r_op),
    .a    (r_a),
    .b    (r_b),
    .y    (w_y),
    .flag (w_flag)
  );

  // Arbitration FSM, operand capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_op        <= OP_AND;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_flag  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_op     <= w_grant1 ? req1_op : req0_op;
            r_a      <= w_grant1 ? req1_a  : req0_a;
            r_b      <= w_grant1 ? req1_b  : req0_b;
            r_id     <= w_grant1;
            r_rr_ptr <= ~w_grant1;   // favour the other requester next time
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_y     <= w_y;
          r_rsp_flag  <= w_flag;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Result fields keep their last value after the handshake.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule : alu_req_arbiter
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_req_arbiter
//  Brief    : Self-checking bench for alu_req_arbiter (WIDTH=8) with a
//             reference arbitration model and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_req_arbiter;

  localparam int WIDTH = 8;

  typedef struct {
    logic       id;
    logic [7:0] y;
    logic       flag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [1:0]       req0_op = 2'b00;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [1:0]       req1_op = 2'b00;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_flag;
  logic             busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  exp_t sb[$];

  // Reference model state: 0 idle, 1 exec, 2 resp
  int   m_state = 0;
  logic m_ptr   = 1'b0;

  alu_req_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_flag   (rsp_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {flag, y} for an 8-bit unsigned op.
  function automatic logic [8:0] alu_ref(input logic [1:0] op, input int a, input int b);
    int y;
    logic f;
    case (op)
      2'b00: begin y = a & b;         f = (y == 0);  end
      2'b01: begin y = (a + b) % 256; f = (a + b > 255); end
      2'b10: begin y = (a - b + 256) % 256; f = (a < b); end
      default: begin
        y = (a < b) ? 4 : ((a > b) ? 2 : 1);
        f = (a == b);
      end
    endcase
    return {f, y[7:0]};
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic e0, e1;
    logic [8:0] r;
    exp_t ex;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_flag", rsp_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      m_state = 0;
      m_ptr   = 1'b0;
      sb.delete();
    end else begin
      e0 = (m_state == 0) && req0_valid && (!req1_valid || !m_ptr);
      e1 = (m_state == 0) && req1_valid && (!req0_valid ||  m_ptr);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("busy", busy, m_state != 0);
      chk("rsp_valid", rsp_valid, m_state == 2);
      case (m_state)
        0: if (e0 || e1) begin
          r = e1 ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
          ex.id = e1; ex.y = r[7:0]; ex.flag = r[8];
          sb.push_back(ex);
          m_ptr   = ~e1;
          m_state = 1;
        end
        1: m_state = 2;
        default: if (rsp_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            ex = sb.pop_front();
            chk("rsp_y", rsp_y, ex.y);
            chk("rsp_flag", rsp_flag, ex.flag);
            chk("rsp_id", rsp_id, ex.id);
          end
          n_rsp++;
          m_state = 0;
        end
      endcase
    end
  end

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit got = 0;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = !busy && (sb.size() == 0);
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] hy;
    logic       hf, hid;
    bit         seen;

    // 1: reset with random inputs, then release
    #1 rst = 1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'($urandom); req0_op = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_valid = 1'($urandom); req1_op = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;

    // 2: single ADD from req0 with carry out
    send(0, 2'b01, 8'hF0, 8'h20);
    wait_idle();

    // 3: contested start, then req0 re-requests immediately
    fork
      begin send(0, 2'b10, 8'h05, 8'h07); send(0, 2'b01, 8'h11, 8'h22); end
      send(1, 2'b11, 8'h09, 8'h09);
    join
    wait_idle();

    // 4: backpressure during RESP
    rsp_ready = 0;
    send(1, 2'b01, 8'h7F, 8'h01);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("bp_rsp_seen", seen, 1);
    hy = rsp_y; hf = rsp_flag; hid = rsp_id;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_y_stable", rsp_y, hy);
      chk("bp_flag_stable", rsp_flag, hf);
      chk("bp_id_stable", rsp_id, hid);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle", busy, 0);
    wait_idle();

    // 5: AND zero result, CMP less-than
    send(0, 2'b00, 8'h0F, 8'hF0);
    wait_idle();
    send(1, 2'b11, 8'h03, 8'h08);
    wait_idle();

    // 6: reset during EXEC drops the op and restores req0 priority
    send(0, 2'b01, 8'h01, 8'h01);   // leaves rr_ptr favouring req1
    rst = 1;                        // now in EXEC
    @(posedge clk); #1 rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_drop_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    fork
      send(0, 2'b00, 8'hAA, 8'hFF);
      send(1, 2'b10, 8'h10, 8'h01);
    join
    wait_idle();

    chk("sb_drained", sb.size(), 0);
    chk("rsp_count", n_rsp, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule : tb_alu_req_arbiter
`default_nettype wire
